// File: rtl/target_pkg.sv
// Shared definitions for the target spawner: default LFSR seed/taps, FSM
// state encoding and the width helper for the retry counter.
package target_pkg;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] TAPS_DEFAULT = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 30; i++) begin
      if ((32'sd1 <<< i) < value) w = i + 1;
    end
    return w;
  endfunction

  // A single permitted try still needs a one-bit counter.
  function automatic int tries_w(input int max_tries);
    return (clog2(max_tries) < 1) ? 1 : clog2(max_tries);
  endfunction

endpackage

// File: rtl/target_spawner_lfsr.sv
// Free-running Galois LFSR with a zero-safe parallel load (a zero load is
// replaced by SEED so the register can never lock up).
module lfsr_galois #(
  parameter int         W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ena,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] lfsr_r;
  logic [W-1:0] step_s;

  // Next state of one Galois shift: feedback applied when the bit shifted out is 1.
  always_comb begin
    if (lfsr_r[0]) begin
      step_s = {1'b0, lfsr_r[W-1:1]} ^ TAPS;
    end else begin
      step_s = {1'b0, lfsr_r[W-1:1]};
    end
  end

  // LFSR register: reset beats load, load beats the enabled step.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= (load_val == {W{1'b0}}) ? SEED : load_val;
    end else if (ena) begin
      lfsr_r <= step_s;
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/target_spawner.sv
// Pseudo-random target generator: rejection-samples LFSR draws into the
// rectangle [0..X_MAX] x [Y_MIN..Y_MAX]. Optional seed port: TARGET_SEED_LOAD_EN.
module target_spawner
  import target_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = TAPS_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED      = SEED_DEFAULT,
  parameter int                X_W       = 5,
  parameter int                Y_W       = 5,
  parameter int                X_MAX     = 31,
  parameter int                Y_MIN     = 30,
  parameter int                Y_MAX     = 31,
  parameter int                MAX_TRIES = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic           target_req,
  output logic [X_W-1:0] target_x,
  output logic [Y_W-1:0] target_y,
  output logic           target_valid,
  output logic           busy
`ifdef TARGET_SEED_LOAD_EN
  ,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value
`endif
);

  localparam int             TW       = tries_w(MAX_TRIES);
  localparam logic [X_W:0]   X_LIM    = (X_W+1)'(X_MAX);
  localparam logic [Y_W-1:0] Y_BASE   = Y_W'(Y_MIN);
  localparam logic [Y_W:0]   Y_SPAN   = (Y_W+1)'(Y_MAX - Y_MIN);
  localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRIES - 1);

  state_t         state_r;
  logic [TW-1:0]  tries_r;
  logic [X_W-1:0] target_x_r;
  logic [Y_W-1:0] target_y_r;
  logic           target_valid_r;

  logic [LFSR_W-1:0] lfsr_s;
  logic [LFSR_W-1:0] seed_val_s;
  logic              seed_load_s;
  logic [X_W-1:0]    cx_s;
  logic [X_W-1:0]    fb_x_s;
  logic [Y_W-1:0]    cy_off_s;
  logic [Y_W:0]      cy_s;
  logic [Y_W:0]      fb_y_s;
  logic              x_ok_s;
  logic              y_ok_s;
  logic              same_s;
  logic              accept_s;
  logic              unused_s;

`ifdef TARGET_SEED_LOAD_EN
  assign seed_load_s = seed_load;
  assign seed_val_s  = seed_value;
`else
  assign seed_load_s = 1'b0;
  assign seed_val_s  = {LFSR_W{1'b0}};
`endif

  lfsr_galois #(
    .W   (LFSR_W),
    .TAPS(TAPS),
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .load    (seed_load_s),
    .load_val(seed_val_s),
    .q       (lfsr_s)
  );

  // Sampler: candidate fields, acceptance test and clamped fallback values.
  always_comb begin
    cx_s     = lfsr_s[X_W-1:0];
    cy_off_s = lfsr_s[X_W +: Y_W];
    cy_s     = {1'b0, Y_BASE} + {1'b0, cy_off_s};
    x_ok_s   = ({1'b0, cx_s} <= X_LIM);
    y_ok_s   = ({1'b0, cy_off_s} <= Y_SPAN);
    same_s   = (cx_s == target_x_r) && (cy_s == {1'b0, target_y_r});
    accept_s = x_ok_s && y_ok_s && !same_s;
    if (x_ok_s) begin
      fb_x_s = cx_s;
    end else begin
      fb_x_s = X_LIM[X_W-1:0];
    end
    if (y_ok_s) begin
      fb_y_s = cy_s;
    end else begin
      fb_y_s = {1'b0, Y_BASE} + Y_SPAN;
    end
  end

  // Upper LFSR bits and carry bits never reach a target field.
  assign unused_s = ^{lfsr_s, cy_s[Y_W], fb_y_s[Y_W]};

  // Request FSM and registered target outputs; ena low freezes everything but the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      tries_r        <= {TW{1'b0}};
      target_x_r     <= {X_W{1'b0}};
      target_y_r     <= Y_BASE;
      target_valid_r <= 1'b0;
    end else if (!ena) begin
      target_valid_r <= 1'b0;
    end else begin
      target_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (target_req) begin
            state_r <= DRAW;
            tries_r <= {TW{1'b0}};
          end
        end
        DRAW: begin
          if (accept_s) begin
            target_x_r     <= cx_s;
            target_y_r     <= cy_s[Y_W-1:0];
            target_valid_r <= 1'b1;
            state_r        <= IDLE;
          end else if (tries_r != LAST_TRY) begin
            tries_r <= tries_r + TW'(1);
          end else begin
            // Out of retries: clamp the last draw into range, repeats allowed.
            target_x_r     <= fb_x_s;
            target_y_r     <= fb_y_s[Y_W-1:0];
            target_valid_r <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign target_x     = target_x_r;
  assign target_y     = target_y_r;
  assign target_valid = target_valid_r;
  assign busy         = (state_r == DRAW);

endmodule

// File: tb/tb_target_spawner.sv
// Scoreboard bench for target_spawner: a cycle model pushes expected targets,
// a negedge monitor pops and compares; directed tests add hand-computed checks.
module tb_target_spawner;

  typedef struct {
    logic [15:0] lfsr;
    logic        st;
    int          tries;
    logic [4:0]  tx;
    logic [4:0]  ty;
    logic        tv;
    logic        fb;
  } ms_t;

  typedef struct packed {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [4:0]  px;
    logic [4:0]  py;
    logic        fb;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        target_req;
  logic        req2;
  logic        seed_load;
  logic [15:0] seed_value;
  logic [4:0]  x1, y1, x2, y2;
  logic        v1, b1, v2, b2;

  int          checks;
  int          errors;
  logic [31:0] cyc;
  ms_t         m1, m2;
  exp_t        q1[$];
  exp_t        q2[$];

  always #5 clk = ~clk;

  target_spawner u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .target_req  (target_req),
    .target_x    (x1),
    .target_y    (y1),
    .target_valid(v1),
    .busy        (b1)
`ifdef TARGET_SEED_LOAD_EN
    ,
    .seed_load   (seed_load),
    .seed_value  (seed_value)
`endif
  );

  target_spawner #(
    .X_MAX(0), .Y_MIN(0), .Y_MAX(0), .MAX_TRIES(8)
  ) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .target_req  (req2),
    .target_x    (x2),
    .target_y    (y2),
    .target_valid(v2),
    .busy        (b2)
`ifdef TARGET_SEED_LOAD_EN
    ,
    .seed_load   (1'b0),
    .seed_value  (16'h0000)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic ms_t minit(input int ymin);
    ms_t s;
    s.lfsr = 16'hACE1; s.st = 1'b0; s.tries = 0;
    s.tx = 5'd0; s.ty = 5'(ymin); s.tv = 1'b0; s.fb = 1'b0;
    return s;
  endfunction

  function automatic ms_t mstep(input ms_t s, input logic req, input logic en, input logic sl,
                                input logic [15:0] sv, input int xmax, input int ymin,
                                input int ymax, input int mt);
    ms_t n;
    int  cx, cyo, cy, span;
    bit  acc;
    n = s; n.tv = 1'b0; n.fb = 1'b0;
    span = ymax - ymin;
    if (sl) n.lfsr = (sv == 16'h0000) ? 16'hACE1 : sv;
    else if (en) n.lfsr = s.lfsr[0] ? ((s.lfsr >> 1) ^ 16'hB400) : (s.lfsr >> 1);
    if (en) begin
      if (!s.st) begin
        if (req) begin n.st = 1'b1; n.tries = 0; end
      end else begin
        cx  = int'(s.lfsr[4:0]);
        cyo = int'(s.lfsr[9:5]);
        cy  = ymin + cyo;
        acc = (cx <= xmax) && (cyo <= span) && !(cx == int'(s.tx) && cy == int'(s.ty));
        if (acc) begin
          n.tx = 5'(cx); n.ty = 5'(cy); n.tv = 1'b1; n.st = 1'b0;
        end else if (s.tries < mt - 1) begin
          n.tries = s.tries + 1;
        end else begin
          n.tx = 5'((cx < xmax) ? cx : xmax);
          n.ty = 5'(ymin + ((cyo < span) ? cyo : span));
          n.tv = 1'b1; n.fb = 1'b1; n.st = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // Reference model: steps on every posedge and queues each expected strobe.
  initial begin
    exp_t e;
    m1 = minit(30); m2 = minit(0); cyc = 32'd0;
    forever begin
      @(posedge clk);
      cyc = cyc + 32'd1;
      if (reset) begin
        m1 = minit(30); m2 = minit(0);
      end else begin
        e.px = m1.tx; e.py = m1.ty;
        m1 = mstep(m1, target_req, ena, seed_load, seed_value, 31, 30, 31, 8);
        if (m1.tv) begin
          e.x = m1.tx; e.y = m1.ty; e.fb = m1.fb; e.cyc = cyc;
          q1.push_back(e);
        end
        e.px = m2.tx; e.py = m2.ty;
        m2 = mstep(m2, req2, ena, 1'b0, 16'h0000, 0, 0, 0, 8);
        if (m2.tv) begin
          e.x = m2.tx; e.y = m2.ty; e.fb = m2.fb; e.cyc = cyc;
          q2.push_back(e);
        end
      end
    end
  end

  task automatic mon_dut(input bit is1, input logic v, input logic [4:0] x, input logic [4:0] y,
                         input logic b, input logic mst);
    exp_t e;
    bit   due;
    if (is1) due = (q1.size() != 0) && (q1[0].cyc == cyc);
    else     due = (q2.size() != 0) && (q2[0].cyc == cyc);
    chk(is1 ? "busy1" : "busy2", 32'(b), 32'(mst));
    chk(is1 ? "valid1" : "valid2", 32'(v), 32'(due));
    if (due) begin
      if (is1) e = q1.pop_front();
      else     e = q2.pop_front();
      chk(is1 ? "x1" : "x2", 32'(x), 32'(e.x));
      chk(is1 ? "y1" : "y2", 32'(y), 32'(e.y));
      if (is1) begin
        chk("y1_range", 32'(y == 5'd30 || y == 5'd31), 32'd1);
        if (!e.fb) chk("no_repeat1", 32'(x == e.px && y == e.py), 32'd0);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      mon_dut(1'b1, v1, x1, y1, b1, m1.st);
      mon_dut(1'b0, v2, x2, y2, b2, m2.st);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_valid1(input int budget, output bit seen);
    int n;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = v1;
    end
  endtask

  initial begin
    bit seen;
    int ngold;
    int nval;
    checks = 0; errors = 0; ngold = 0; nval = 0;
    reset = 1'b1; ena = 1'b1; target_req = 1'b0; req2 = 1'b0;
    seed_load = 1'b0; seed_value = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_x", 32'(x1), 32'd0);
    chk("rst_y", 32'(y1), 32'd30);
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_busy", 32'(b1), 32'd0);
    chk("rst_lfsr", 32'(u_dut1.u_lfsr.q), 32'h0000ACE1);
    chk("rst_y2", 32'(y2), 32'd0);
    reset = 1'b0;

    // Golden run against the model.
    for (int i = 0; i < 100; i++) begin
      target_req = 1'b1;
      @(negedge clk);
      target_req = 1'b0;
      wait_valid1(12, seen);
      if (seen) ngold++;
    end
    chk("golden_count", 32'(ngold), 32'd100);

    // Forced fallback: every draw collides with (0,0).
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    chk("fb_busy_k1", 32'(b2), 32'd1);
    chk("fb_novalid_k1", 32'(v2), 32'd0);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      chk("fb_busy", 32'(b2), 32'd1);
      chk("fb_novalid", 32'(v2), 32'd0);
    end
    @(negedge clk);
    chk("fb_valid", 32'(v2), 32'd1);
    chk("fb_x", 32'(x2), 32'd0);
    chk("fb_y", 32'(y2), 32'd0);
    chk("fb_idle", 32'(b2), 32'd0);

    // ena low for 5 cycles mid-DRAW: completion moves from k9 to k14.
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      chk("frz_busy", 32'(b2), 32'd1);
      chk("frz_valid", 32'(v2), 32'd0);
      chk("frz_lfsr", 32'(u_dut2.u_lfsr.q), 32'(m2.lfsr));
      chk("frz_tries", 32'(u_dut2.tries_r), 32'(m2.tries));
    end
    ena = 1'b1;
    for (int k = 9; k <= 13; k++) begin
      @(negedge clk);
      chk("frz_late_valid", 32'(v2), 32'd0);
    end
    @(negedge clk);
    chk("frz_done_valid", 32'(v2), 32'd1);

    // Reset mid-DRAW: no strobe, back to IDLE.
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_busy2", 32'(b2), 32'd0);
    chk("rstmid_valid2", 32'(v2), 32'd0);
    chk("rstmid_busy1", 32'(b1), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rstmid_nostrobe", 32'(v2), 32'd0);
    end

    // Second request while busy is dropped.
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    repeat (2) @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v2) nval++;
    end
    chk("busy_req_count", 32'(nval), 32'd1);

`ifdef TARGET_SEED_LOAD_EN
    // Seed load ignores ena; zero is substituted by the reset seed.
    ena = 1'b0;
    seed_value = 16'h0000;
    seed_load = 1'b1;
    @(negedge clk);
    chk("seed_zero", 32'(u_dut1.u_lfsr.q), 32'h0000ACE1);
    ena = 1'b1;
    seed_value = 16'h0001;
    @(negedge clk);
    chk("seed_one", 32'(u_dut1.u_lfsr.q), 32'h00000001);
    seed_load = 1'b0;
    @(negedge clk);
    chk("seed_step", 32'(u_dut1.u_lfsr.q), 32'h0000B400);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
